// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection,
// bubble insertion on stall/flush, and M/W operand forwarding into execute.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int ALUCW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [3:0]       ra1_d,
  input  logic [3:0]       ra2_d,
  input  logic             use1_d,
  input  logic             use2_d,
  input  logic [3:0]       wa3_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] extimm_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             alusrc_d,
  input  logic [ALUCW-1:0] alucontrol_d,
  input  logic             flush_e,
  input  logic [3:0]       wa3_m,
  input  logic             regwrite_m,
  input  logic [WIDTH-1:0] aluresult_m,
  input  logic [3:0]       wa3_w,
  input  logic             regwrite_w,
  input  logic [WIDTH-1:0] result_w,
  output logic             stall_d,
  output logic             valid_e,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [3:0]       wa3_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic [ALUCW-1:0] alucontrol_e,
  output logic [WIDTH-1:0] extimm_e
);

  localparam logic [3:0] PC_REG = 4'd15;

  logic             valid_q;
  logic [3:0]       ra1_q;
  logic [3:0]       ra2_q;
  logic [3:0]       wa3_q;
  logic [WIDTH-1:0] rd1_q;
  logic [WIDTH-1:0] rd2_q;
  logic [WIDTH-1:0] extimm_q;
  logic             regwrite_q;
  logic             memtoreg_q;
  logic             memwrite_q;
  logic             alusrc_q;
  logic [ALUCW-1:0] alucontrol_q;

  logic loadInE;
  logic hit1;
  logic hit2;
  logic bubble;

  // A load's data is not available until W, so a dependent in D must wait one cycle.
  // Loads into the PC never create a hazard because r15 is never forwarded.
  always_comb begin
    loadInE = valid_q & regwrite_q & memtoreg_q & (wa3_q != PC_REG);
    hit1    = use1_d & (ra1_d == wa3_q);
    hit2    = use2_d & (ra2_d == wa3_q);
    stall_d = loadInE & valid_d & (hit1 | hit2);
    bubble  = stall_d | flush_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ra1_q        <= '0;
      ra2_q        <= '0;
      wa3_q        <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      extimm_q     <= '0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      alucontrol_q <= '0;
    end else if (bubble) begin
      valid_q      <= 1'b0;
      ra1_q        <= '0;
      ra2_q        <= '0;
      wa3_q        <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      extimm_q     <= '0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      alucontrol_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ra1_q        <= ra1_d;
      ra2_q        <= ra2_d;
      wa3_q        <= wa3_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      extimm_q     <= extimm_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memwrite_q   <= memwrite_d;
      alusrc_q     <= alusrc_d;
      alucontrol_q <= alucontrol_d;
    end
  end

  // The younger result (M) wins over W; r15 always comes from the register file.
  function automatic logic [WIDTH-1:0] forwardOperand(
    input logic [3:0]       ra,
    input logic [WIDTH-1:0] rdCaptured,
    input logic [3:0]       wam,
    input logic             rwm,
    input logic [WIDTH-1:0] resm,
    input logic [3:0]       waw,
    input logic             rww,
    input logic [WIDTH-1:0] resw
  );
    logic [WIDTH-1:0] sel;
    sel = rdCaptured;
    if (ra != PC_REG) begin
      if (rwm && (wam == ra)) begin
        sel = resm;
      end else if (rww && (waw == ra)) begin
        sel = resw;
      end
    end
    return sel;
  endfunction

  always_comb begin
    srca_e      = forwardOperand(ra1_q, rd1_q, wa3_m, regwrite_m, aluresult_m,
                                 wa3_w, regwrite_w, result_w);
    writedata_e = forwardOperand(ra2_q, rd2_q, wa3_m, regwrite_m, aluresult_m,
                                 wa3_w, regwrite_w, result_w);
    srcb_e      = alusrc_q ? extimm_q : writedata_e;
  end

  assign valid_e      = valid_q;
  assign wa3_e        = wa3_q;
  assign regwrite_e   = regwrite_q;
  assign memtoreg_e   = memtoreg_q;
  assign memwrite_e   = memwrite_q;
  assign alucontrol_e = alucontrol_q;
  assign extimm_e     = extimm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: the stimulus pushes hand-computed
// expectations, and a negedge monitor pops and compares them.
module tb_id_ex_stage;

  localparam int WIDTH = 32;
  localparam int ALUCW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_d;
  logic [3:0]       ra1_d, ra2_d, wa3_d;
  logic             use1_d, use2_d;
  logic [WIDTH-1:0] rd1_d, rd2_d, extimm_d;
  logic             regwrite_d, memtoreg_d, memwrite_d, alusrc_d;
  logic [ALUCW-1:0] alucontrol_d;
  logic             flush_e;
  logic [3:0]       wa3_m, wa3_w;
  logic             regwrite_m, regwrite_w;
  logic [WIDTH-1:0] aluresult_m, result_w;
  logic             stall_d, valid_e;
  logic [WIDTH-1:0] srca_e, writedata_e, srcb_e, extimm_e;
  logic [3:0]       wa3_e;
  logic             regwrite_e, memtoreg_e, memwrite_e;
  logic [ALUCW-1:0] alucontrol_e;

  typedef struct {
    logic        v;
    logic [3:0]  ra1, ra2;
    logic        u1, u2;
    logic [3:0]  wa3;
    logic [31:0] rd1, rd2, imm;
    logic        rw, m2r, mw, asrc;
    logic [1:0]  aluc;
  } instr_t;

  typedef struct {
    logic [3:0]  wm;
    logic        rwm;
    logic [31:0] alum;
    logic [3:0]  ww;
    logic        rww;
    logic [31:0] resw;
  } ctx_t;

  typedef struct {
    logic        v, rw, m2r, mw, stall;
    logic [3:0]  wa3;
    logic [1:0]  aluc;
    logic [31:0] imm, srca, wd, srcb;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage #(.WIDTH(WIDTH), .ALUCW(ALUCW)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .ra1_d(ra1_d), .ra2_d(ra2_d),
    .use1_d(use1_d), .use2_d(use2_d), .wa3_d(wa3_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .extimm_d(extimm_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
    .memwrite_d(memwrite_d), .alusrc_d(alusrc_d), .alucontrol_d(alucontrol_d),
    .flush_e(flush_e), .wa3_m(wa3_m), .regwrite_m(regwrite_m),
    .aluresult_m(aluresult_m), .wa3_w(wa3_w), .regwrite_w(regwrite_w),
    .result_w(result_w), .stall_d(stall_d), .valid_e(valid_e), .srca_e(srca_e),
    .writedata_e(writedata_e), .srcb_e(srcb_e), .wa3_e(wa3_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .alucontrol_e(alucontrol_e), .extimm_e(extimm_e)
  );

  always #5 clk = ~clk;

  function automatic instr_t mkInstr(
    input logic v, input logic [3:0] ra1, input logic u1, input logic [3:0] ra2,
    input logic u2, input logic [3:0] wa3, input logic [31:0] rd1,
    input logic [31:0] rd2, input logic [31:0] imm, input logic rw,
    input logic m2r, input logic mw, input logic asrc, input logic [1:0] aluc
  );
    instr_t i;
    i.v = v; i.ra1 = ra1; i.u1 = u1; i.ra2 = ra2; i.u2 = u2; i.wa3 = wa3;
    i.rd1 = rd1; i.rd2 = rd2; i.imm = imm; i.rw = rw; i.m2r = m2r; i.mw = mw;
    i.asrc = asrc; i.aluc = aluc;
    return i;
  endfunction

  function automatic ctx_t mkCtx(
    input logic [3:0] wm, input logic rwm, input logic [31:0] alum,
    input logic [3:0] ww, input logic rww, input logic [31:0] resw
  );
    ctx_t c;
    c.wm = wm; c.rwm = rwm; c.alum = alum; c.ww = ww; c.rww = rww; c.resw = resw;
    return c;
  endfunction

  // Control fields come from whichever instruction is known to sit in E;
  // operand values are written out by hand at each call.
  function automatic exp_t mkExp(
    input instr_t i, input logic [31:0] sa, input logic [31:0] wd,
    input logic [31:0] sb, input logic st
  );
    exp_t e;
    e.v = i.v; e.rw = i.rw; e.m2r = i.m2r; e.mw = i.mw; e.wa3 = i.wa3;
    e.aluc = i.aluc; e.imm = i.imm; e.srca = sa; e.wd = wd; e.srcb = sb;
    e.stall = st;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk("valid_e", 32'(valid_e), 32'(e.v));
    chk("regwrite_e", 32'(regwrite_e), 32'(e.rw));
    chk("memtoreg_e", 32'(memtoreg_e), 32'(e.m2r));
    chk("memwrite_e", 32'(memwrite_e), 32'(e.mw));
    chk("wa3_e", 32'(wa3_e), 32'(e.wa3));
    chk("alucontrol_e", 32'(alucontrol_e), 32'(e.aluc));
    chk("extimm_e", extimm_e, e.imm);
    chk("srca_e", srca_e, e.srca);
    chk("writedata_e", writedata_e, e.wd);
    chk("srcb_e", srcb_e, e.srcb);
    chk("stall_d", 32'(stall_d), 32'(e.stall));
  endtask

  task automatic driveInstr(input instr_t d);
    valid_d = d.v; ra1_d = d.ra1; use1_d = d.u1; ra2_d = d.ra2; use2_d = d.u2;
    wa3_d = d.wa3; rd1_d = d.rd1; rd2_d = d.rd2; extimm_d = d.imm;
    regwrite_d = d.rw; memtoreg_d = d.m2r; memwrite_d = d.mw;
    alusrc_d = d.asrc; alucontrol_d = d.aluc;
  endtask

  // Drive D (for the next edge) plus the M/W context seen by the instruction now in E.
  task automatic applyStimulus(input instr_t d, input logic fl, input ctx_t c, input exp_t e);
    @(posedge clk);
    #1;
    driveInstr(d);
    flush_e = fl;
    wa3_m = c.wm; regwrite_m = c.rwm; aluresult_m = c.alum;
    wa3_w = c.ww; regwrite_w = c.rww; result_w = c.resw;
    expQ.push_back(e);
  endtask

  task automatic randomInputs();
    driveInstr(mkInstr(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
                       1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       2'($urandom)));
    flush_e = 1'($urandom);
    wa3_m = 4'($urandom); regwrite_m = 1'($urandom); aluresult_m = $urandom;
    wa3_w = 4'($urandom); regwrite_w = 1'($urandom); result_w = $urandom;
  endtask

  // Monitor: pops one expectation per cycle while the pipeline runs.
  always @(negedge clk) begin
    if (!reset && expQ.size() > 0) begin
      cur = expQ.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t idle, a, b, ld5, dep, e1, ld15, e2, st;
    ctx_t   none;
    exp_t   zeroE;
    int     waitCycles;

    idle = mkInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    a    = mkInstr(1, 3, 1, 4, 1, 6, 32'h11, 32'h22, 32'h100, 1, 0, 0, 0, 2);
    b    = mkInstr(1, 3, 1, 7, 1, 8, 32'h33, 32'h44, 32'h5, 1, 0, 0, 1, 1);
    ld5  = mkInstr(1, 1, 1, 0, 0, 5, 32'h1000, 0, 32'h4, 1, 1, 0, 1, 0);
    dep  = mkInstr(1, 2, 1, 5, 1, 9, 32'h77, 32'hDEAD, 0, 1, 0, 0, 0, 3);
    e1   = mkInstr(1, 5, 0, 6, 1, 10, 32'h1, 32'h2, 0, 1, 0, 0, 0, 0);
    ld15 = mkInstr(1, 1, 1, 0, 0, 15, 32'h2000, 0, 32'h8, 1, 1, 0, 1, 0);
    e2   = mkInstr(1, 15, 1, 15, 1, 1, 32'h300, 32'h400, 0, 1, 0, 0, 0, 1);
    st   = mkInstr(1, 2, 1, 3, 1, 0, 32'h10, 32'h20, 32'hC, 0, 0, 1, 1, 0);
    none = mkCtx(0, 0, 0, 0, 0, 0);
    zeroE = mkExp(idle, 0, 0, 0, 0);

    // Reset with random inputs: execute must read as empty.
    reset = 1'b1;
    randomInputs();
    #1;
    checkOutput(zeroE);
    repeat (3) begin
      @(negedge clk);
      randomInputs();
      #1;
      chk("reset valid_e", 32'(valid_e), 0);
      chk("reset regwrite_e", 32'(regwrite_e), 0);
      chk("reset memwrite_e", 32'(memwrite_e), 0);
      chk("reset stall_d", 32'(stall_d), 0);
    end
    @(negedge clk);
    driveInstr(idle);
    flush_e = 0;
    wa3_m = 0; regwrite_m = 0; aluresult_m = 0;
    wa3_w = 0; regwrite_w = 0; result_w = 0;
    reset = 1'b0;

    // First instruction and M-over-W forwarding.
    applyStimulus(a, 0, none, zeroE);
    applyStimulus(b, 0, mkCtx(3, 1, 32'hAA, 3, 1, 32'h55),
                  mkExp(a, 32'hAA, 32'h22, 32'h22, 0));
    applyStimulus(ld5, 0, mkCtx(3, 0, 32'hAA, 3, 1, 32'h55),
                  mkExp(b, 32'h55, 32'h44, 32'h5, 0));
    // Load-use: one stall, one bubble, then W forwarding.
    applyStimulus(dep, 0, none, mkExp(ld5, 32'h1000, 0, 32'h4, 1));
    applyStimulus(dep, 0, none, zeroE);
    applyStimulus(idle, 0, mkCtx(0, 0, 0, 5, 1, 32'hBEEF),
                  mkExp(dep, 32'h77, 32'hBEEF, 32'hBEEF, 0));
    // No spurious stall: unused source, load into r15.
    applyStimulus(ld5, 0, none, zeroE);
    applyStimulus(e1, 0, none, mkExp(ld5, 32'h1000, 0, 32'h4, 0));
    applyStimulus(ld15, 0, none, mkExp(e1, 32'h1, 32'h2, 32'h2, 0));
    applyStimulus(e2, 0, none, mkExp(ld15, 32'h2000, 0, 32'h8, 0));
    // PC never forwarded; store flushed on its way into E.
    applyStimulus(st, 1, mkCtx(15, 1, 32'h1234, 0, 0, 0),
                  mkExp(e2, 32'h300, 32'h400, 32'h400, 0));
    applyStimulus(st, 0, none, zeroE);
    applyStimulus(idle, 0, none, mkExp(st, 32'h10, 32'h20, 32'hC, 0));
    // Stall and flush together: a single bubble.
    applyStimulus(ld5, 0, none, zeroE);
    applyStimulus(dep, 1, none, mkExp(ld5, 32'h1000, 0, 32'h4, 1));
    applyStimulus(dep, 0, none, zeroE);
    applyStimulus(idle, 0, mkCtx(0, 0, 0, 5, 1, 32'hBEEF),
                  mkExp(dep, 32'h77, 32'hBEEF, 32'hBEEF, 0));
    applyStimulus(idle, 0, none, zeroE);
    // Reset arriving while a stall is active.
    applyStimulus(ld5, 0, none, zeroE);
    applyStimulus(dep, 0, none, mkExp(ld5, 32'h1000, 0, 32'h4, 1));

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checks++;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    #2;
    reset = 1'b1;
    #1;
    chk("midstall reset stall_d", 32'(stall_d), 0);
    chk("midstall reset valid_e", 32'(valid_e), 0);
    chk("midstall reset memtoreg_e", 32'(memtoreg_e), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
